pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline-stage register for the 5-stage RISC-V core. It is the generic successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds valid/ready flow control, synchronous flush with control-bit kill, an optional 2-entry skid buffer for full throughput with a registered `in_ready`, and a saturating stall counter. Each stage boundary instantiates one copy, with datapath and control fields packed into separate buses.

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/sat_counter.sv | 36 +++
 rtl/pipe_stage_reg.sv | 178 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage registers of the 5-stage core.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 96;
  localparam int unsigned PIPE_CTRL_W = 8;
  localparam int unsigned PIPE_CNT_W  = 16;

  // Occupancy of a two-entry skid stage
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // ID/EX control bundle, cast to PIPE_CTRL_W bits at the stage boundary
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
  } id_ex_ctrl_t;

  // EX/MEM control bundle
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jump;
    logic       u_type;
    logic [1:0] rsvd;
  } ex_mem_ctrl_t;

  // MEM/WB control bundle
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       jump;
    logic       u_type;
    logic [3:0] rsvd;
  } mem_wb_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;

  // Next count: clear, else increment unless already at all-ones
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      w_cnt_nxt = r_cnt + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register with flush, optional skid buffer and stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic [CTRL_W-1:0] w_out_ctrl_raw;
  logic              w_stall_inc;

  assign w_in_fire = in_valid & w_in_ready;

  if (SKID != 0) begin : g_skid

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_EMPTY;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    // Next state and payload load enables; flush kills everything and loads nothing
    always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
        w_state_nxt = ST_EMPTY;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_fire) begin
              w_state_nxt    = ST_BUSY;
              w_load_main_in = 1'b1;
            end
          end
          ST_BUSY: begin
            if (w_in_fire && out_ready) begin
              w_load_main_in = 1'b1;
            end else if (w_in_fire) begin
              w_state_nxt = ST_FULL;
              w_load_skid = 1'b1;
            end else if (out_ready) begin
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (out_ready) begin
              w_state_nxt      = ST_BUSY;
              w_load_main_skid = 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_EMPTY;
          end
        endcase
      end
    end

    // Main and skid payload registers; contents survive flush and emptying
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_main_data <= '0;
        r_main_ctrl <= '0;
        r_skid_data <= '0;
        r_skid_ctrl <= '0;
      end else begin
        if (w_load_main_in) begin
          r_main_data <= in_data;
          r_main_ctrl <= in_ctrl;
        end else if (w_load_main_skid) begin
          r_main_data <= r_skid_data;
          r_main_ctrl <= r_skid_ctrl;
        end
        if (w_load_skid) begin
          r_skid_data <= in_data;
          r_skid_ctrl <= in_ctrl;
        end
      end
    end

    assign w_in_ready     = (r_state != ST_FULL);
    assign w_out_valid    = (r_state != ST_EMPTY);
    assign w_out_data     = r_main_data;
    assign w_out_ctrl_raw = r_main_ctrl;

  end else begin : g_noskid

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;
    logic              w_out_fire;

    assign w_out_fire = r_valid & out_ready;

    // Valid bit: flush clears, accept sets, drain without refill clears
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
      end else if (flush) begin
        r_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_valid <= 1'b0;
      end
    end

    // Payload register, loaded only by an accepted, non-flushed entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data <= '0;
        r_ctrl <= '0;
      end else if (w_in_fire && !flush) begin
        r_data <= in_data;
        r_ctrl <= in_ctrl;
      end
    end

    assign w_in_ready     = ~r_valid | out_ready;
    assign w_out_valid    = r_valid;
    assign w_out_data     = r_data;
    assign w_out_ctrl_raw = r_ctrl;

  end

  assign w_stall_inc = w_out_valid & ~out_ready;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .clr   (stall_clr),
    .cnt   (stall_cnt)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_data;
  assign out_ctrl  = w_out_ctrl_raw & {CTRL_W{w_out_valid}};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: SKID=1/CNT_W=16 and SKID=0/CNT_W=4 stages driven by the same stimulus.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 96;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;
  logic          stall_clr;

  logic          ir0, ov0, ir1, ov1;
  logic [DW-1:0] od0, od1;
  logic [CW-1:0] oc0, oc1;
  logic [3:0]    sc0;
  logic [15:0]   sc1;

  int   vectors;
  int   miscompares;
  ent_t q0[$];
  ent_t q1[$];
  int   cnt_exp[2];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
    .stall_cnt(sc1), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
    .stall_cnt(sc0), .stall_clr(stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input logic [127:0] act,
                     input logic [127:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s dut_skid%0d: got 0x%0h, expected 0x%0h at %0t",
               name, k, act, exp_v, $time);
    end
  endtask

  // Reference model: a FIFO of at most 1 (SKID=0) or 2 (SKID=1) held entries
  task automatic mon(input int k, input logic v, input logic r,
                     input logic [DW-1:0] d, input logic [CW-1:0] c, input int sc);
    int   sz;
    int   cmax;
    ent_t e;
    cmax = (k == 1) ? 65535 : 15;
    if (!rst_n) begin
      chk("rst_out_valid", k, v, 1'b0);
      chk("rst_in_ready", k, r, 1'b1);
      chk("rst_out_data", k, d, '0);
      chk("rst_out_ctrl", k, c, '0);
      chk("rst_stall_cnt", k, sc, '0);
      if (k == 1) q1.delete(); else q0.delete();
      cnt_exp[k] = 0;
      return;
    end
    e  = '0;
    sz = (k == 1) ? q1.size() : q0.size();
    if (sz > 0) e = (k == 1) ? q1[0] : q0[0];
    chk("out_valid", k, v, sz > 0);
    chk("in_ready", k, r, (k == 1) ? (sz < 2) : (sz == 0 || out_ready));
    chk("stall_cnt", k, sc, cnt_exp[k]);
    if (sz == 0) begin
      chk("out_ctrl_gated", k, c, '0);
    end else begin
      chk("out_data", k, d, e.d);
      chk("out_ctrl", k, c, e.c);
      if (out_ready) begin
        if (k == 1) void'(q1.pop_front()); else void'(q0.pop_front());
      end
    end
    if (stall_clr) cnt_exp[k] = 0;
    else if (sz > 0 && !out_ready && cnt_exp[k] < cmax) cnt_exp[k]++;
    if (flush) begin
      if (k == 1) q1.delete(); else q0.delete();
    end
  endtask

  // Monitor: compares every cycle, well after inputs change and before the edge
  always begin
    @(negedge clk);
    #1;
    mon(0, ov0, ir0, od0, oc0, int'(sc0));
    mon(1, ov1, ir1, od1, oc1, int'(sc1));
  end

  // Expected-entry producer: records each entry the upstream hands over
  always begin
    @(negedge clk);
    #2;
    if (rst_n && in_valid && !flush) begin
      if (ir0) q0.push_back('{d: in_data, c: in_ctrl});
      if (ir1) q1.push_back('{d: in_data, c: in_ctrl});
    end
  end

  task automatic drv(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic ordy, input logic fl, input logic clr);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
  endtask

  initial begin
    int item;
    int cyc;
    vectors     = 0;
    miscompares = 0;
    cnt_exp[0]  = 0;
    cnt_exp[1]  = 0;
    rst_n       = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b1;
    in_data     = DW'(96'h55);
    in_ctrl     = CW'(8'hFF);
    out_ready   = 1'b1;
    stall_clr   = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held with in_valid=1, then a single pass-through entry
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    in_data  = DW'(96'hA5);
    in_ctrl  = CW'(8'h03);
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("pass_data", 1, od1, DW'(96'hA5));
    chk("pass_ctrl", 0, oc0, CW'(8'h03));
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: stream 1..4, out_ready low for the first four cycles
    item = 1;
    cyc  = 0;
    while (item <= 4 && cyc < 40) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = DW'(item);
      in_ctrl   = CW'(item);
      out_ready = (cyc >= 4);
      flush     = 1'b0;
      stall_clr = 1'b0;
      #2;
      if (cyc == 3) begin
        chk("bp_full_in_ready", 1, ir1, 1'b0);
        chk("bp_full_main", 1, od1, DW'(1));
      end
      if (ir1) item++;
      cyc++;
    end
    chk("bp_stream_done", 1, item, 5);
    repeat (4) drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL, with a competing input entry 7
    drv(1'b1, DW'(10), CW'(10), 1'b0, 1'b0, 1'b0);
    drv(1'b1, DW'(11), CW'(11), 1'b0, 1'b0, 1'b0);
    drv(1'b1, DW'(7), CW'(7), 1'b0, 1'b1, 1'b0);
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("flush_out_valid", 1, ov1, 1'b0);
    chk("flush_out_ctrl", 1, oc1, '0);
    chk("flush_in_ready", 1, ir1, 1'b1);
    chk("flush_data_hold", 1, od1, DW'(10));
    chk("flush_data_hold", 0, od0, DW'(10));

    // Stall counter: clear, then five stall cycles
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    drv(1'b1, DW'(20), CW'(20), 1'b0, 1'b0, 1'b0);
    repeat (5) drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("stall_five", 1, sc1, 16'd5);
    chk("stall_five", 0, sc0, 4'd5);
    // Clear coinciding with a stall cycle
    drv(1'b1, DW'(21), CW'(21), 1'b0, 1'b0, 1'b0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("stall_clr_wins", 1, sc1, 16'd0);
    chk("stall_clr_wins", 0, sc0, 4'd0);
    // Saturation of the 4-bit counter
    repeat (19) drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("stall_sat", 0, sc0, 4'd15);
    chk("stall_nosat", 1, sc1, 16'd20);
    repeat (2) drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset while BUSY
    drv(1'b1, DW'(30), CW'(30), 1'b0, 1'b0, 1'b0);
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_async_valid", 1, ov1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 1, ov1, 1'b0);
    chk("async_out_valid", 0, ov0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with varying density, rare flushes and clears
    for (int i = 0; i < 6000; i++) begin
      int pv;
      int pr;
      pv = (i < 2000) ? 3 : ((i < 4000) ? 1 : 2);
      pr = (i < 2000) ? 1 : ((i < 4000) ? 3 : 2);
      drv($urandom_range(0, 3) < pv, {$urandom(), $urandom(), $urandom()},
          CW'($urandom()), $urandom_range(0, 3) < pr,
          $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
    end

    // Steady full-rate streaming
    for (int i = 0; i < 64; i++) begin
      drv(1'b1, {$urandom(), $urandom(), $urandom()}, CW'($urandom()),
          1'b1, 1'b0, 1'b0);
    end
    repeat (4) drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
